// File: rtl/ring_arb_pkg.sv
// ---------------------------------------------------------------------------
// ring_arb_pkg
// Shared types and helpers for the ring link arbiter slice.
//   arb_state_e : packet-lock FSM states (IDLE, LOCK_RING, LOCK_LOC)
//   arb_sel_e   : combinational source select (none / RING / LOCAL)
//   flitIsTail  : returns the tail flag (bit width-1) of a flit
//   STAT_W      : width of the optional packet statistics counters
// ---------------------------------------------------------------------------
package ring_arb_pkg;

  localparam int STAT_W     = 16;
  localparam int FLIT_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOCK_RING = 2'd1,
    LOCK_LOC  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RING = 2'd1,
    SEL_LOC  = 2'd2
  } arb_sel_e;

  // Flits narrower than FLIT_MAX_W are zero-extended by the caller; the
  // tail flag always sits in the flit's own top bit.
  function automatic logic flitIsTail(input logic [FLIT_MAX_W-1:0] flit,
                                      input int unsigned            width);
    logic [5:0] tail_idx;
    tail_idx = 6'(width - 1);
    return flit[tail_idx];
  endfunction

endpackage

// File: rtl/ring_arb_sat_cnt.sv
// ---------------------------------------------------------------------------
// ring_arb_sat_cnt
// Saturating up-counter used for per-source completed-packet statistics.
// Ports:
//   clk   in  1  clock
//   i_clr in  1  synchronous clear (highest priority)
//   i_inc in  1  increment by one, holds at all-ones
//   o_cnt out W  current count
// ---------------------------------------------------------------------------
module ring_arb_sat_cnt
  import ring_arb_pkg::*;
#(
  parameter int W = STAT_W
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ring_link_arbiter.sv
// ---------------------------------------------------------------------------
// ring_link_arbiter
// Shares one ring output link between ring pass-through (RING) and local
// injection (LOCAL). Arbitration is packet-locked and weighted: RING may win
// up to RING_WEIGHT consecutive packets while LOCAL waits, then LOCAL gets
// one packet. FIFO read enables are driven straight from the link handshake,
// so no flit storage lives here.
//
// Optional feature macro: RING_LINK_ARB_STAT_EN
//   When defined, adds oRingPktCnt / oLocPktCnt (16-bit saturating counts of
//   completed packets per source, cleared by rst).
//
// Ports:
//   clk          in   1      clock
//   rst          in   1      synchronous active-high reset
//   iRingEmpty   in   1      RING FIFO empty
//   iRingDat     in   WIDTH  RING FIFO head flit
//   oRingRdEn    out  1      pop RING FIFO
//   iLocEmpty    in   1      LOCAL FIFO empty
//   iLocDat      in   WIDTH  LOCAL FIFO head flit
//   oLocRdEn     out  1      pop LOCAL FIFO
//   oLinkVld     out  1      oLinkDat valid
//   oLinkDat     out  WIDTH  flit to downstream link
//   iLinkRdy     in   1      downstream ready
//   oBusy        out  1      packet lock held
//   oRingPktCnt  out  16     (stat build only) RING packets completed
//   oLocPktCnt   out  16     (stat build only) LOCAL packets completed
// ---------------------------------------------------------------------------
module ring_link_arbiter
  import ring_arb_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int RING_WEIGHT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iRingEmpty,
  input  logic [WIDTH-1:0] iRingDat,
  output logic             oRingRdEn,
  input  logic             iLocEmpty,
  input  logic [WIDTH-1:0] iLocDat,
  output logic             oLocRdEn,
  output logic             oLinkVld,
  output logic [WIDTH-1:0] oLinkDat,
  input  logic             iLinkRdy,
  output logic             oBusy
`ifdef RING_LINK_ARB_STAT_EN
  ,
  output logic [STAT_W-1:0] oRingPktCnt,
  output logic [STAT_W-1:0] oLocPktCnt
`endif
);

  localparam int                CRED_W   = $clog2(RING_WEIGHT + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(RING_WEIGHT);

  arb_state_e        r_state;
  arb_state_e        w_stateNxt;
  logic [CRED_W-1:0] r_credit;
  logic [CRED_W-1:0] w_creditNxt;
  arb_sel_e          w_sel;
  logic              w_vld;
  logic [WIDTH-1:0]  w_selDat;
  logic              w_xfer;
  logic              w_tail;

  // Source select. Forcing SEL_NONE during reset zeroes every output,
  // including the data path, without a separate output mux.
  always_comb begin
    w_sel = SEL_NONE;
    case (r_state)
      IDLE: begin
        if (!iRingEmpty && !iLocEmpty) begin
          w_sel = (r_credit != '0) ? SEL_RING : SEL_LOC;
        end else if (!iRingEmpty) begin
          w_sel = SEL_RING;
        end else if (!iLocEmpty) begin
          w_sel = SEL_LOC;
        end
      end
      LOCK_RING: w_sel = SEL_RING;
      LOCK_LOC:  w_sel = SEL_LOC;
      default:   w_sel = SEL_NONE;
    endcase
    if (rst) begin
      w_sel = SEL_NONE;
    end
  end

  // Valid depends only on state and FIFO status, never on iLinkRdy.
  always_comb begin
    w_vld    = 1'b0;
    w_selDat = '0;
    case (w_sel)
      SEL_RING: begin
        w_vld    = !iRingEmpty;
        w_selDat = iRingDat;
      end
      SEL_LOC: begin
        w_vld    = !iLocEmpty;
        w_selDat = iLocDat;
      end
      default: begin
        w_vld    = 1'b0;
        w_selDat = '0;
      end
    endcase
  end

  assign w_xfer = w_vld & iLinkRdy;
  assign w_tail = flitIsTail(FLIT_MAX_W'(w_selDat), WIDTH);

  // Next state and credit only move on an actual transfer.
  always_comb begin
    w_stateNxt  = r_state;
    w_creditNxt = r_credit;
    if (w_xfer) begin
      if (w_tail) begin
        w_stateNxt = IDLE;
        // RING keeps spending credit only while LOCAL is actually waiting.
        if ((w_sel == SEL_RING) && !iLocEmpty) begin
          w_creditNxt = (r_credit == '0) ? '0 : (r_credit - CRED_W'(1));
        end else begin
          w_creditNxt = CRED_MAX;
        end
      end else if (r_state == IDLE) begin
        w_stateNxt = (w_sel == SEL_RING) ? LOCK_RING : LOCK_LOC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_credit <= CRED_MAX;
    end else begin
      r_state  <= w_stateNxt;
      r_credit <= w_creditNxt;
    end
  end

  assign oLinkVld  = w_vld;
  assign oLinkDat  = w_selDat;
  assign oRingRdEn = w_xfer && (w_sel == SEL_RING);
  assign oLocRdEn  = w_xfer && (w_sel == SEL_LOC);
  assign oBusy     = !rst && (r_state != IDLE);

`ifdef RING_LINK_ARB_STAT_EN
  logic w_ringDone;
  logic w_locDone;

  assign w_ringDone = oRingRdEn && w_tail;
  assign w_locDone  = oLocRdEn && w_tail;

  ring_arb_sat_cnt #(.W(STAT_W)) u_ringPktCnt (
    .clk   (clk),
    .i_clr (rst),
    .i_inc (w_ringDone),
    .o_cnt (oRingPktCnt)
  );

  ring_arb_sat_cnt #(.W(STAT_W)) u_locPktCnt (
    .clk   (clk),
    .i_clr (rst),
    .i_inc (w_locDone),
    .o_cnt (oLocPktCnt)
  );
`endif

endmodule

// File: tb/tb_ring_link_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ring_link_arbiter
// Directed bench for ring_link_arbiter (WIDTH=8, RING_WEIGHT=2). Two queues
// stand in for the RING and LOCAL FIFOs; inputs change on the falling edge,
// outputs are checked just after, and the queues pop on the rising edge when
// the matching read enable was seen.
// ---------------------------------------------------------------------------
module tb_ring_link_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       iRingEmpty;
  logic [7:0] iRingDat;
  logic       oRingRdEn;
  logic       iLocEmpty;
  logic [7:0] iLocDat;
  logic       oLocRdEn;
  logic       oLinkVld;
  logic [7:0] oLinkDat;
  logic       iLinkRdy;
  logic       oBusy;
`ifdef RING_LINK_ARB_STAT_EN
  logic [15:0] oRingPktCnt;
  logic [15:0] oLocPktCnt;
`endif

  ring_link_arbiter #(.WIDTH(8), .RING_WEIGHT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .iRingEmpty (iRingEmpty),
    .iRingDat   (iRingDat),
    .oRingRdEn  (oRingRdEn),
    .iLocEmpty  (iLocEmpty),
    .iLocDat    (iLocDat),
    .oLocRdEn   (oLocRdEn),
    .oLinkVld   (oLinkVld),
    .oLinkDat   (oLinkDat),
    .iLinkRdy   (iLinkRdy),
    .oBusy      (oBusy)
`ifdef RING_LINK_ARB_STAT_EN
    ,
    .oRingPktCnt (oRingPktCnt),
    .oLocPktCnt  (oLocPktCnt)
`endif
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_mis = 0;
  logic [7:0] ring_q[$];
  logic [7:0] loc_q[$];
  logic       ring_stall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    iRingEmpty = (ring_q.size() == 0) || ring_stall;
    iRingDat   = (ring_q.size() != 0) ? ring_q[0] : 8'h00;
    iLocEmpty  = (loc_q.size() == 0);
    iLocDat    = (loc_q.size() != 0) ? loc_q[0] : 8'h00;
    #1;
  endtask

  // Check one cycle's outputs, then let the clock edge happen.
  task automatic cyc(input string tag, input logic vld, input logic [7:0] dat,
                     input logic rr, input logic lr, input logic busy,
                     input logic chk_dat);
    logic rr_s, lr_s;
    chk({tag, "_vld"},  32'(oLinkVld),  32'(vld));
    if (chk_dat) chk({tag, "_dat"}, 32'(oLinkDat), 32'(dat));
    chk({tag, "_rrd"},  32'(oRingRdEn), 32'(rr));
    chk({tag, "_lrd"},  32'(oLocRdEn),  32'(lr));
    chk({tag, "_busy"}, 32'(oBusy),     32'(busy));
    rr_s = oRingRdEn;
    lr_s = oLocRdEn;
    @(posedge clk);
    if (rr_s && ring_q.size() != 0) void'(ring_q.pop_front());
    if (lr_s && loc_q.size() != 0)  void'(loc_q.pop_front());
    @(negedge clk);
    settle();
  endtask

  initial begin
    rst      = 1'b1;
    iLinkRdy = 1'b1;
    @(negedge clk);
    settle();

    // 1: reset / idle, including a LOCAL head present during reset
    cyc("t1_rst0", 0, 8'h00, 0, 0, 0, 1);
    cyc("t1_rst1", 0, 8'h00, 0, 0, 0, 1);
    loc_q.push_back(8'h55);
    settle();
    cyc("t1_rst_pend", 0, 8'h00, 0, 0, 0, 1);
    loc_q.delete();
    rst = 1'b0;
    settle();
    chk("t1_credit", 32'(dut.r_credit), 32'd2);
    cyc("t1_idle", 0, 8'h00, 0, 0, 0, 1);

    // 2: single LOCAL packet 01,02,83
    loc_q = '{8'h01, 8'h02, 8'h83};
    settle();
    cyc("t2_f0", 1, 8'h01, 0, 1, 0, 1);
    cyc("t2_f1", 1, 8'h02, 0, 1, 1, 1);
    cyc("t2_f2", 1, 8'h83, 0, 1, 1, 1);
    cyc("t2_done", 0, 8'h00, 0, 0, 0, 1);

    // 3: weighting R,R,L,R,R,L with single-flit packets
    rst = 1'b1;
    settle();
    cyc("t3_rst", 0, 8'h00, 0, 0, 0, 1);
    rst = 1'b0;
    settle();
`ifdef RING_LINK_ARB_STAT_EN
    chk("t3_rcnt0", 32'(oRingPktCnt), 32'd0);
    chk("t3_lcnt0", 32'(oLocPktCnt),  32'd0);
`endif
    for (int i = 0; i < 6; i++) begin
      ring_q.push_back(8'h90 + 8'(i));
      loc_q.push_back(8'hA0 + 8'(i));
    end
    settle();
    cyc("t3_g0", 1, 8'h90, 1, 0, 0, 1);
    cyc("t3_g1", 1, 8'h91, 1, 0, 0, 1);
    cyc("t3_g2", 1, 8'hA0, 0, 1, 0, 1);
    cyc("t3_g3", 1, 8'h92, 1, 0, 0, 1);
    cyc("t3_g4", 1, 8'h93, 1, 0, 0, 1);
    cyc("t3_g5", 1, 8'hA1, 0, 1, 0, 1);
    chk("t3_credit", 32'(dut.r_credit), 32'd2);
`ifdef RING_LINK_ARB_STAT_EN
    chk("t3_rcnt", 32'(oRingPktCnt), 32'd4);
    chk("t3_lcnt", 32'(oLocPktCnt),  32'd2);
`endif
    ring_q.delete();
    loc_q.delete();
    settle();
    cyc("t3_flush", 0, 8'h00, 0, 0, 0, 1);

    // 4: packet lock while RING starves mid-packet
    ring_q = '{8'h11, 8'h12, 8'h93};
    loc_q  = '{8'hA6, 8'hA7};
    settle();
    cyc("t4_head", 1, 8'h11, 1, 0, 0, 1);
    ring_stall = 1'b1;
    settle();
    for (int i = 0; i < 4; i++) cyc("t4_stall", 0, 8'h00, 0, 0, 1, 0);
    ring_stall = 1'b0;
    settle();
    cyc("t4_f1", 1, 8'h12, 1, 0, 1, 1);
    cyc("t4_f2", 1, 8'h93, 1, 0, 1, 1);
    chk("t4_credit_dec", 32'(dut.r_credit), 32'd1);
    cyc("t4_loc0", 1, 8'hA6, 0, 1, 0, 1);
    chk("t4_credit_rld", 32'(dut.r_credit), 32'd2);
    cyc("t4_loc1", 1, 8'hA7, 0, 1, 0, 1);
    cyc("t4_done", 0, 8'h00, 0, 0, 0, 1);

    // 5: backpressure on the tail flit
    ring_q = '{8'h21, 8'h22, 8'hB3};
    loc_q  = '{8'hC4};
    settle();
    cyc("t5_f0", 1, 8'h21, 1, 0, 0, 1);
    cyc("t5_f1", 1, 8'h22, 1, 0, 1, 1);
    iLinkRdy = 1'b0;
    settle();
    for (int i = 0; i < 5; i++) begin
      cyc("t5_bp", 1, 8'hB3, 0, 0, 1, 1);
      chk("t5_bp_credit", 32'(dut.r_credit), 32'd2);
    end
    iLinkRdy = 1'b1;
    settle();
    cyc("t5_f2", 1, 8'hB3, 1, 0, 1, 1);
    chk("t5_credit", 32'(dut.r_credit), 32'd1);
    cyc("t5_loc", 1, 8'hC4, 0, 1, 0, 1);
    cyc("t5_done", 0, 8'h00, 0, 0, 0, 1);

    // 6: reset mid-packet
    ring_q = '{8'hC1};
    loc_q  = '{8'h31, 8'h32, 8'hB3};
    settle();
    cyc("t6_ring", 1, 8'hC1, 1, 0, 0, 1);
    chk("t6_credit_dec", 32'(dut.r_credit), 32'd1);
    cyc("t6_l0", 1, 8'h31, 0, 1, 0, 1);
    chk("t6_locked", 32'(oBusy), 32'd1);
    rst = 1'b1;
    settle();
    cyc("t6_rst", 0, 8'h00, 0, 0, 0, 1);
    rst = 1'b0;
    settle();
    chk("t6_credit_rst", 32'(dut.r_credit), 32'd2);
`ifdef RING_LINK_ARB_STAT_EN
    chk("t6_rcnt0", 32'(oRingPktCnt), 32'd0);
    chk("t6_lcnt0", 32'(oLocPktCnt),  32'd0);
`endif
    cyc("t6_restart", 1, 8'h32, 0, 1, 0, 1);
    cyc("t6_tail", 1, 8'hB3, 0, 1, 1, 1);
    cyc("t6_done", 0, 8'h00, 0, 0, 0, 1);
`ifdef RING_LINK_ARB_STAT_EN
    chk("t6_lcnt1", 32'(oLocPktCnt), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
